kband_m0_arbiter: RTL and testbench



---
 rtl/kband_m0_arbiter_pkg.sv | 40 ++++
 rtl/kband_m0_arbiter_if.sv | 52 +++++
 rtl/kband_m0_arbiter_id_fifo.sv | 56 +++++
 rtl/kband_m0_arbiter.sv | 138 +++++++++++++
 tb/tb_kband_m0_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/kband_m0_arbiter_pkg.sv
// Shared types and widths for the KBand m0 arbiter: requester IDs, FSM states
// and the entry format of the outstanding-read ID FIFO.
package kband_pkg;

  localparam int AW  = 30;
  localparam int DW  = 128;
  localparam int BEW = DW / 8;
  localparam int BCW = 5;

  typedef enum logic [1:0] {
    REQ_RD1 = 2'd0,
    REQ_RD2 = 2'd1,
    REQ_WR  = 2'd2
  } req_id_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_CMD   = 2'd1,
    ST_WR_BURST = 2'd2
  } state_t;

  typedef struct packed {
    req_id_t        id;
    logic [BCW-1:0] beats;
  } id_entry_t;

  function automatic req_id_t next_req(input req_id_t r);
    case (r)
      REQ_RD1: return REQ_RD2;
      REQ_RD2: return REQ_WR;
      default: return REQ_RD1;
    endcase
  endfunction

  // A zero-length burst is treated as a single beat so the counters never underflow.
  function automatic logic [BCW-1:0] coerce_burst(input logic [BCW-1:0] bc);
    return (bc == '0) ? BCW'(1) : bc;
  endfunction

endpackage

// File: rtl/kband_m0_arbiter_if.sv
// Requester and m0 Avalon-MM signal bundle; the arbiter takes the master view,
// the surrounding DMA engines and memory take the slave view.
interface kband_m0_arbiter_if;
  import kband_pkg::*;

  logic           rd1_read, rd2_read;
  logic [AW-1:0]  rd1_address, rd2_address;
  logic [BCW-1:0] rd1_burstcount, rd2_burstcount;
  logic           rd1_waitrequest, rd2_waitrequest;
  logic [DW-1:0]  rd1_readdata, rd2_readdata;
  logic           rd1_readdatavalid, rd2_readdatavalid;

  logic           wr_write;
  logic [AW-1:0]  wr_address;
  logic [BCW-1:0] wr_burstcount;
  logic [DW-1:0]  wr_writedata;
  logic [BEW-1:0] wr_byteenable;
  logic           wr_waitrequest;

  logic           m0_waitrequest;
  logic [DW-1:0]  m0_readdata;
  logic           m0_readdatavalid;
  logic [AW-1:0]  m0_address;
  logic [BCW-1:0] m0_burstcount;
  logic           m0_read, m0_write;
  logic [DW-1:0]  m0_writedata;
  logic [BEW-1:0] m0_byteenable;
  logic           m0_debugaccess;

  modport master (
    input  rd1_read, rd1_address, rd1_burstcount, rd2_read, rd2_address, rd2_burstcount,
    output rd1_waitrequest, rd1_readdata, rd1_readdatavalid,
    output rd2_waitrequest, rd2_readdata, rd2_readdatavalid,
    input  wr_write, wr_address, wr_burstcount, wr_writedata, wr_byteenable,
    output wr_waitrequest,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m0_address, m0_burstcount, m0_read, m0_write, m0_writedata, m0_byteenable,
    output m0_debugaccess
  );

  modport slave (
    output rd1_read, rd1_address, rd1_burstcount, rd2_read, rd2_address, rd2_burstcount,
    input  rd1_waitrequest, rd1_readdata, rd1_readdatavalid,
    input  rd2_waitrequest, rd2_readdata, rd2_readdatavalid,
    output wr_write, wr_address, wr_burstcount, wr_writedata, wr_byteenable,
    input  wr_waitrequest,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m0_address, m0_burstcount, m0_read, m0_write, m0_writedata, m0_byteenable,
    input  m0_debugaccess
  );

endinterface

// File: rtl/kband_m0_arbiter_id_fifo.sv
// Outstanding-read tracker: DEPTH entries of {owner id, burst length}, with
// simultaneous push and pop supported.
module kband_id_fifo
  import kband_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  id_entry_t     push_data,
  input  logic          pop,
  output id_entry_t     head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  id_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  // Push while full is dropped; the arbiter never grants a read when full.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/kband_m0_arbiter.sv
// Round-robin, burst-locked arbiter sharing Avalon-MM master m0 between two
// pipelined read streams and one write stream.
module kband_m0_arbiter
  import kband_pkg::*;
#(
  parameter int MAX_PENDING = 4
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  kband_m0_arbiter_if.master  bus
);

  localparam int CW = $clog2(MAX_PENDING + 1);

  state_t         state, state_nxt;
  req_id_t        rr_ptr, owner, grant_id, cand;
  logic           grant_vld, wr_beat, rd_vld_ok, last_beat, rd_err;
  logic [2:0]     elig;
  logic [AW-1:0]  sel_addr, m0_addr_q;
  logic [BCW-1:0] sel_bc, m0_bc_q, wr_left, ret_cnt;
  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  id_entry_t      fifo_head, push_entry;

  assign push_entry = '{id: owner, beats: m0_bc_q};

  kband_id_fifo #(.DEPTH(MAX_PENDING)) u_id_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Grant selection: first eligible requester at or after the RR pointer
  always_comb begin
    elig      = {bus.wr_write, bus.rd2_read & ~fifo_full, bus.rd1_read & ~fifo_full};
    grant_vld = 1'b0;
    grant_id  = REQ_RD1;
    cand      = rr_ptr;
    for (int i = 0; i < 3; i++) begin
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
      cand = next_req(cand);
    end
    case (grant_id)
      REQ_RD1: begin sel_addr = bus.rd1_address; sel_bc = bus.rd1_burstcount; end
      REQ_RD2: begin sel_addr = bus.rd2_address; sel_bc = bus.rd2_burstcount; end
      default: begin sel_addr = bus.wr_address;  sel_bc = bus.wr_burstcount;  end
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= ST_IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fifo_push = 1'b0;
    wr_beat   = 1'b0;
    case (state)
      ST_IDLE:
        if (grant_vld) state_nxt = (grant_id == REQ_WR) ? ST_WR_BURST : ST_RD_CMD;
      ST_RD_CMD:
        if (!bus.m0_waitrequest) begin
          fifo_push = 1'b1;
          state_nxt = ST_IDLE;
        end
      ST_WR_BURST: begin
        wr_beat = bus.wr_write & ~bus.m0_waitrequest;
        if (wr_beat && wr_left == BCW'(1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rr_ptr    <= REQ_RD1;
      owner     <= REQ_RD1;
      m0_addr_q <= '0;
      m0_bc_q   <= '0;
      wr_left   <= '0;
    end else if (state == ST_IDLE && grant_vld) begin
      owner     <= grant_id;
      rr_ptr    <= next_req(grant_id);
      m0_addr_q <= sel_addr;
      m0_bc_q   <= coerce_burst(sel_bc);
      wr_left   <= coerce_burst(sel_bc);
    end else if (wr_beat) begin
      wr_left   <= wr_left - BCW'(1);
    end
  end

  // Return path: beats belong to the oldest outstanding burst
  assign rd_vld_ok = bus.m0_readdatavalid & ~fifo_empty;
  assign last_beat = (ret_cnt + BCW'(1)) == fifo_head.beats;
  assign fifo_pop  = rd_vld_ok & last_beat;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ret_cnt <= '0;
      rd_err  <= 1'b0;
    end else begin
      if (rd_vld_ok) ret_cnt <= last_beat ? '0 : ret_cnt + BCW'(1);
      if (bus.m0_readdatavalid && fifo_empty) rd_err <= 1'b1;
    end
  end

  assign bus.rd1_waitrequest   = ~(state == ST_RD_CMD && owner == REQ_RD1 && !bus.m0_waitrequest);
  assign bus.rd2_waitrequest   = ~(state == ST_RD_CMD && owner == REQ_RD2 && !bus.m0_waitrequest);
  assign bus.wr_waitrequest    = (state == ST_WR_BURST) ? bus.m0_waitrequest : 1'b1;
  assign bus.rd1_readdata      = bus.m0_readdata;
  assign bus.rd2_readdata      = bus.m0_readdata;
  assign bus.rd1_readdatavalid = rd_vld_ok & (fifo_head.id == REQ_RD1);
  assign bus.rd2_readdatavalid = rd_vld_ok & (fifo_head.id == REQ_RD2);

  assign bus.m0_address     = m0_addr_q;
  assign bus.m0_burstcount  = m0_bc_q;
  assign bus.m0_read        = (state == ST_RD_CMD);
  assign bus.m0_write       = (state == ST_WR_BURST) & bus.wr_write;
  assign bus.m0_writedata   = bus.wr_writedata;
  assign bus.m0_byteenable  = (state == ST_WR_BURST) ? bus.wr_byteenable :
                              (state == ST_RD_CMD)   ? '1 : '0;
  assign bus.m0_debugaccess = 1'b0;

  no_orphan_beat: assert property (@(posedge clk_clk) disable iff (!reset_reset_n) !rd_err);
  fifo_in_range:  assert property (@(posedge clk_clk) disable iff (!reset_reset_n)
                                   fifo_count <= CW'(MAX_PENDING));

endmodule

// File: tb/tb_kband_m0_arbiter.sv
// Directed bench for kband_m0_arbiter: reset, single read, rotation under
// contention, stalled write burst, full ID FIFO, interleaved returns, mid-burst reset.
module tb_kband_m0_arbiter;
  import kband_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   acc, widx, mcnt;
  logic gapped;

  int         seq2 [18] = '{0, 1, 0, 2, 0, 3, 3, 0, 1, 0, 2, 0, 3, 3, 0, 3, 3, 0};
  logic [1:0] rt2  [8]  = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};

  kband_m0_arbiter_if bus ();

  kband_m0_arbiter dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  task automatic chkv(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  // {m0_read, m0_write, rd1_waitrequest, rd2_waitrequest, wr_waitrequest}
  function automatic logic [4:0] ctl();
    return {bus.m0_read, bus.m0_write, bus.rd1_waitrequest, bus.rd2_waitrequest, bus.wr_waitrequest};
  endfunction

  function automatic logic [4:0] ctl_of(input int code);
    case (code)
      1:       return 5'b10011;
      2:       return 5'b10101;
      3:       return 5'b01110;
      default: return 5'b00111;
    endcase
  endfunction

  function automatic logic [DW-1:0] wdat(input int i);
    return {4{32'h1000_0000 + 32'(i)}};
  endfunction

  function automatic logic [BEW-1:0] wbe(input int i);
    return (16'h0001 << i) | 16'h8000;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    nx();
    nx();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rd1_read = 0; bus.rd1_address = '0; bus.rd1_burstcount = '0;
    bus.rd2_read = 0; bus.rd2_address = '0; bus.rd2_burstcount = '0;
    bus.wr_write = 0; bus.wr_address = '0; bus.wr_burstcount = '0;
    bus.wr_writedata = '0; bus.wr_byteenable = '0;
    bus.m0_waitrequest = 0; bus.m0_readdata = '0; bus.m0_readdatavalid = 0;

    // Reset values
    nx(); #1;
    chkv("rst_ctl", 128'(ctl()), 128'(5'b00111));
    chkv("rst_addr", 128'(bus.m0_address), 128'(30'h0));
    chkv("rst_bc", 128'(bus.m0_burstcount), 128'(5'd0));
    chkv("rst_be", 128'(bus.m0_byteenable), 128'(16'h0));
    chkv("rst_rdv", 128'({bus.rd2_readdatavalid, bus.rd1_readdatavalid}), 128'(2'b00));
    chkv("rst_dbg", 128'(bus.m0_debugaccess), 128'(1'b0));
    rst_n = 1'b1;

    // Single read: rd1 @0x100 x4
    nx();
    bus.rd1_read = 1; bus.rd1_address = 30'h100; bus.rd1_burstcount = 5'd4;
    #1 chkv("sr_req_ctl", 128'(ctl()), 128'(5'b00111));
    nx(); #1;
    chkv("sr_cmd_ctl", 128'(ctl()), 128'(5'b10011));
    chkv("sr_cmd_addr", 128'(bus.m0_address), 128'(30'h100));
    chkv("sr_cmd_bc", 128'(bus.m0_burstcount), 128'(5'd4));
    chkv("sr_cmd_be", 128'(bus.m0_byteenable), 128'(16'hFFFF));
    bus.rd1_read = 0;
    nx(); #1 chkv("sr_post_ctl", 128'(ctl()), 128'(5'b00111));
    for (int i = 0; i < 4; i++) begin
      if (i > 0) nx();
      bus.m0_readdatavalid = 1; bus.m0_readdata = 128'hC0 + 128'(i);
      #1;
      chkv($sformatf("sr_rdv%0d", i), 128'({bus.rd2_readdatavalid, bus.rd1_readdatavalid}), 128'(2'b01));
      chkv($sformatf("sr_data%0d", i), bus.rd1_readdata, 128'hC0 + 128'(i));
    end
    nx(); bus.m0_readdatavalid = 0;

    // Contention: all three requesting, burst 2
    do_reset();
    bus.rd1_read = 1; bus.rd1_address = 30'h10; bus.rd1_burstcount = 5'd2;
    bus.rd2_read = 1; bus.rd2_address = 30'h20; bus.rd2_burstcount = 5'd2;
    bus.wr_write = 1; bus.wr_address = 30'h30; bus.wr_burstcount = 5'd2;
    bus.wr_writedata = {4{32'hCAFE_F00D}}; bus.wr_byteenable = 16'h0F0F;
    for (int i = 0; i < 18; i++) begin
      if (i > 0) nx();
      if (i == 17) begin bus.rd1_read = 0; bus.rd2_read = 0; bus.wr_write = 0; end
      #1;
      chkv($sformatf("ct_ctl%0d", i), 128'(ctl()), 128'(ctl_of(seq2[i])));
      if (seq2[i] == 1) chkv($sformatf("ct_addr%0d", i), 128'(bus.m0_address), 128'(30'h10));
      if (seq2[i] == 2) chkv($sformatf("ct_addr%0d", i), 128'(bus.m0_address), 128'(30'h20));
      if (seq2[i] == 3) begin
        chkv($sformatf("ct_addr%0d", i), 128'(bus.m0_address), 128'(30'h30));
        chkv($sformatf("ct_be%0d", i), 128'(bus.m0_byteenable), 128'(16'h0F0F));
        chkv($sformatf("ct_wd%0d", i), bus.m0_writedata, {4{32'hCAFE_F00D}});
      end
    end
    for (int i = 0; i < 8; i++) begin
      nx();
      bus.m0_readdatavalid = 1; bus.m0_readdata = 128'hD0 + 128'(i);
      #1 chkv($sformatf("ct_route%0d", i), 128'({bus.rd2_readdatavalid, bus.rd1_readdatavalid}), 128'(rt2[i]));
    end
    nx(); bus.m0_readdatavalid = 0;

    // Write burst of 8 with m0 stalls and a one-cycle gap at beat 3
    bus.wr_address = 30'h200; bus.wr_burstcount = 5'd8;
    widx = 0; mcnt = 0; gapped = 0;
    for (int cyc = 0; cyc < 40 && mcnt < 8; cyc++) begin
      nx();
      bus.m0_waitrequest = cyc[0];
      if (widx == 2 && !gapped) begin bus.wr_write = 0; gapped = 1; end
      else bus.wr_write = (widx < 8);
      bus.wr_writedata = wdat(widx); bus.wr_byteenable = wbe(widx);
      #1;
      if (bus.m0_write) chkv($sformatf("wb_wait%0d", cyc), 128'(bus.wr_waitrequest), 128'(bus.m0_waitrequest));
      if (bus.m0_write && !bus.m0_waitrequest) begin
        chkv($sformatf("wb_data%0d", mcnt), bus.m0_writedata, wdat(mcnt));
        chkv($sformatf("wb_be%0d", mcnt), 128'(bus.m0_byteenable), 128'(wbe(mcnt)));
        chkv($sformatf("wb_addr%0d", mcnt), 128'({bus.m0_address, bus.m0_burstcount}), 128'({30'h200, 5'd8}));
        mcnt++;
      end
      if (bus.wr_write && !bus.wr_waitrequest) widx++;
    end
    chkv("wb_beats", 128'(mcnt), 128'(8));
    nx(); bus.wr_write = 0; bus.m0_waitrequest = 0;
    #1 chkv("wb_idle_ctl", 128'(ctl()), 128'(5'b00111));

    // FIFO full: four single-beat reads outstanding, then wr still granted
    bus.rd1_read = 1; bus.rd1_address = 30'h600; bus.rd1_burstcount = 5'd1;
    acc = 0;
    for (int cyc = 0; cyc < 20 && acc < 4; cyc++) begin
      nx(); #1;
      if (!bus.rd1_waitrequest) acc++;
    end
    chkv("ff_accepts", 128'(acc), 128'(4));
    nx(); #1 chkv("ff_held_ctl", 128'(ctl()), 128'(5'b00111));
    bus.wr_write = 1; bus.wr_address = 30'h700; bus.wr_burstcount = 5'd1;
    nx(); #1;
    chkv("ff_wr_ctl", 128'(ctl()), 128'(5'b01110));
    chkv("ff_wr_addr", 128'(bus.m0_address), 128'(30'h700));
    nx(); bus.wr_write = 0;
    #1 chkv("ff_held2_ctl", 128'(ctl()), 128'(5'b00111));
    bus.m0_readdatavalid = 1; bus.m0_readdata = 128'hE0;
    #1 chkv("ff_ret_rdv", 128'({bus.rd2_readdatavalid, bus.rd1_readdatavalid}), 128'(2'b01));
    nx(); bus.m0_readdatavalid = 0;
    #1 chkv("ff_grant_ctl", 128'(ctl()), 128'(5'b00111));
    nx(); #1;
    chkv("ff_5th_ctl", 128'(ctl()), 128'(5'b10011));
    chkv("ff_5th_addr", 128'(bus.m0_address), 128'(30'h600));
    bus.rd1_read = 0;
    for (int i = 0; i < 4; i++) begin
      nx();
      bus.m0_readdatavalid = 1;
      #1 chkv($sformatf("ff_drain%0d", i), 128'({bus.rd2_readdatavalid, bus.rd1_readdatavalid}), 128'(2'b01));
    end
    nx(); bus.m0_readdatavalid = 0;

    // Interleaved returns: rd1 x3 then rd2 x2, rd2 accepted on rd1's last beat
    bus.rd1_read = 1; bus.rd1_address = 30'h300; bus.rd1_burstcount = 5'd3;
    nx(); #1;
    chkv("il_c1_ctl", 128'(ctl()), 128'(5'b10011));
    chkv("il_c1_cmd", 128'({bus.m0_address, bus.m0_burstcount}), 128'({30'h300, 5'd3}));
    bus.rd1_read = 0;
    bus.rd2_read = 1; bus.rd2_address = 30'h400; bus.rd2_burstcount = 5'd2;
    nx(); bus.m0_readdatavalid = 1; bus.m0_readdata = 128'hF1;
    #1 chkv("il_c2_rdv", 128'({bus.rd2_readdatavalid, bus.rd1_readdatavalid}), 128'(2'b01));
    nx(); bus.m0_waitrequest = 1; bus.m0_readdata = 128'hF2;
    #1;
    chkv("il_c3_rdv", 128'({bus.rd2_readdatavalid, bus.rd1_readdatavalid}), 128'(2'b01));
    chkv("il_c3_ctl", 128'(ctl()), 128'(5'b10111));
    chkv("il_c3_addr", 128'(bus.m0_address), 128'(30'h400));
    nx(); bus.m0_waitrequest = 0; bus.m0_readdata = 128'hF3;
    #1;
    chkv("il_c4_rdv", 128'({bus.rd2_readdatavalid, bus.rd1_readdatavalid}), 128'(2'b01));
    chkv("il_c4_ctl", 128'(ctl()), 128'(5'b10101));
    chkv("il_c4_data", bus.rd1_readdata, 128'hF3);
    bus.rd2_read = 0;
    nx(); bus.m0_readdata = 128'hF4;
    #1;
    chkv("il_c5_rdv", 128'({bus.rd2_readdatavalid, bus.rd1_readdatavalid}), 128'(2'b10));
    chkv("il_c5_data", bus.rd2_readdata, 128'hF4);
    chkv("il_c5_ctl", 128'(ctl()), 128'(5'b00111));
    nx(); #1 chkv("il_c6_rdv", 128'({bus.rd2_readdatavalid, bus.rd1_readdatavalid}), 128'(2'b10));
    nx(); bus.m0_readdatavalid = 0;
    #1 chkv("il_c7_rdv", 128'({bus.rd2_readdatavalid, bus.rd1_readdatavalid}), 128'(2'b00));

    // Reset during beat 2 of a 4-beat write
    bus.wr_write = 1; bus.wr_address = 30'h500; bus.wr_burstcount = 5'd4;
    nx(); #1 chkv("rm_b1_ctl", 128'(ctl()), 128'(5'b01110));
    nx(); #1 chkv("rm_b2_ctl", 128'(ctl()), 128'(5'b01110));
    rst_n = 1'b0;
    #1;
    chkv("rm_rst_ctl", 128'(ctl()), 128'(5'b00111));
    chkv("rm_rst_cmd", 128'({bus.m0_address, bus.m0_burstcount}), 128'(35'h0));
    chkv("rm_rst_be", 128'(bus.m0_byteenable), 128'(16'h0));
    nx(); nx();
    rst_n = 1'b1;
    bus.rd1_read = 1; bus.rd1_address = 30'h800; bus.rd1_burstcount = 5'd0;
    bus.rd2_read = 1; bus.rd2_address = 30'h900; bus.rd2_burstcount = 5'd1;
    bus.wr_address = 30'hA00;
    nx(); #1;
    chkv("rm_first_ctl", 128'(ctl()), 128'(5'b10011));
    chkv("rm_first_cmd", 128'({bus.m0_address, bus.m0_burstcount}), 128'({30'h800, 5'd1}));
    bus.rd1_read = 0; bus.rd2_read = 0; bus.wr_write = 0;
    nx(); #1 chkv("rm_end_ctl", 128'(ctl()), 128'(5'b00111));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
